// File: rtl/score_button_ctrl.sv
// score_button_ctrl: four-button front end for a score counter.
// Each raw pushbutton is synchronized, debounced and turned into a pending
// press flag; a fixed-priority arbiter (il > ir > dr > dl) issues registered,
// one-clock command pulses separated by at least one idle clock.
// Optional feature macro: SCORE_AUTOREPEAT_EN re-arms a held button after
// HOLD_CYCLES and then every REPEAT_CYCLES until release.
module score_button_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned HOLD_CYCLES     = 50000000,
   parameter int unsigned REPEAT_CYCLES   = 20000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_il,
   input  logic btn_ir,
   input  logic btn_dl,
   input  logic btn_dr,
   output logic il,
   output logic ir,
   output logic dl,
   output logic dr
);

   // Button index order doubles as arbitration priority: 0 wins.
   localparam int unsigned NB  = 4;
   localparam int unsigned DBW = 24;
   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

   // Reject parameter values the counters cannot represent.
   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 32'h00FF_FFFF ||
       HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
      $error("score_button_ctrl: cycle parameter out of range");
   end

   logic [NB-1:0]  btn_raw;
   logic [NB-1:0]  sync1_q, sync2_q;
   logic [NB-1:0]  db_q, db_d;
   logic [DBW-1:0] db_cnt_q [NB];
   logic [DBW-1:0] db_cnt_d [NB];
   logic [NB-1:0]  acc_d;
   logic [NB-1:0]  ev_all_d;
   logic [NB-1:0]  ev_q;
   logic [NB-1:0]  pend_q, pend_d;
   logic [NB-1:0]  grant;
   logic [NB-1:0]  out_q, out_d;
   logic           gap_q, gap_d;

   assign btn_raw = {btn_dl, btn_dr, btn_ir, btn_il};

   // Two-flop synchronizer for every raw button.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   // Debounce: toggle the level after DEBOUNCE_CYCLES consecutive differing samples.
   always_comb begin
      db_d  = db_q;
      acc_d = '0;
      for (int i = 0; i < NB; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != db_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               db_d[i]  = sync2_q[i];
               acc_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
            end
         end
      end
   end

`ifdef SCORE_AUTOREPEAT_EN
   localparam int unsigned HCW = 32;
   localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
   localparam logic [HCW-1:0] REP_LAST  = HCW'(REPEAT_CYCLES - 1);

   logic [HCW-1:0] hold_cnt_q [NB];
   logic [HCW-1:0] hold_cnt_d [NB];
   logic [NB-1:0]  rep_q, rep_d;
   logic [NB-1:0]  rep_hit;

   // Hold/repeat timer: runs while the level stays high, restarts on every hit.
   always_comb begin
      rep_d   = '0;
      rep_hit = '0;
      for (int i = 0; i < NB; i++) begin
         hold_cnt_d[i] = '0;
         if (db_q[i] && db_d[i]) begin
            if ((!rep_q[i] && hold_cnt_q[i] == HOLD_LAST) ||
                ( rep_q[i] && hold_cnt_q[i] == REP_LAST)) begin
               rep_hit[i] = 1'b1;
               rep_d[i]   = 1'b1;
            end else begin
               hold_cnt_d[i] = hold_cnt_q[i] + HCW'(1);
               rep_d[i]      = rep_q[i];
            end
         end
      end
   end

   // Hold/repeat state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rep_q <= '0;
         for (int i = 0; i < NB; i++) hold_cnt_q[i] <= '0;
      end else begin
         rep_q <= rep_d;
         for (int i = 0; i < NB; i++) hold_cnt_q[i] <= hold_cnt_d[i];
      end
   end

   assign ev_all_d = acc_d | rep_hit;
`else
   assign ev_all_d = acc_d;
`endif

   // Fixed-priority arbiter with one idle clock after every issued pulse.
   always_comb begin
      grant = '0;
      if (!gap_q) begin
         if      (pend_q[0]) grant = 4'b0001;
         else if (pend_q[1]) grant = 4'b0010;
         else if (pend_q[2]) grant = 4'b0100;
         else if (pend_q[3]) grant = 4'b1000;
      end
      out_d  = grant;
      gap_d  = |grant;
      pend_d = (pend_q & ~grant) | ev_q;
   end

   // Debounce, press-event, pending and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_q   <= '0;
         ev_q   <= '0;
         pend_q <= '0;
         out_q  <= '0;
         gap_q  <= 1'b0;
         for (int i = 0; i < NB; i++) db_cnt_q[i] <= '0;
      end else begin
         db_q   <= db_d;
         ev_q   <= ev_all_d;
         pend_q <= pend_d;
         out_q  <= out_d;
         gap_q  <= gap_d;
         for (int i = 0; i < NB; i++) db_cnt_q[i] <= db_cnt_d[i];
      end
   end

   assign il = out_q[0];
   assign ir = out_q[1];
   assign dr = out_q[2];
   assign dl = out_q[3];

endmodule
